// File: rtl/dds_hop_seq.sv
// Frequency-hopping sequencer for a DDS parallel port.
// Holds a 4-entry FTW table. Each hop streams one entry as six byte writes,
// MSB first, to registers 0x04..0x09, then requests a one-cycle I/O update
// and dwells for hop_period cycles before the next hop. Host byte writes share
// the command port and are only granted while idle or dwelling.
module dds_hop_seq (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [47:0] cfg_ftw,
    input  logic        hop_en,
    input  logic [15:0] hop_period,
    input  logic [1:0]  hop_last,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [5:0]  host_addr,
    input  logic [7:0]  host_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [5:0]  cmd_addr,
    output logic [7:0]  cmd_data,
    output logic        dds_ioup,
    output logic        busy,
    output logic [1:0]  hop_idx,
    output logic        hop_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_IOUP = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic [2:0] LAST_BYTE = 3'd5;

    logic [1:0]  state_q, state_d;
    logic [47:0] table_q [4];
    logic [47:0] sbuf_q;
    logic [2:0]  byte_cnt_q;
    logic [15:0] dwell_cnt_q;
    logic [1:0]  hop_idx_q, hop_idx_d;
    logic        stop_q, stop_d;

    logic [15:0] eff_period;
    logic        wait_last;
    logic        send_acc;
    logic        load_entry;
    logic [1:0]  next_idx;
    logic        host_grant;

    // Dwell length with zero treated as one cycle; wait_last flags the final WAIT cycle.
    always_comb begin
        eff_period = (hop_period == 16'd0) ? 16'd1 : hop_period;
        // >= keeps the dwell bounded if hop_period is lowered mid-dwell.
        wait_last  = (dwell_cnt_q >= (eff_period - 16'd1));
        send_acc   = (state_q == ST_SEND) && cmd_ready;
        // An index past a freshly lowered wrap point restarts the table.
        next_idx   = (hop_idx_q >= hop_last) ? 2'd0 : (hop_idx_q + 2'd1);
    end

    // Next-state logic; load_entry marks every transition into SEND.
    always_comb begin
        state_d    = state_q;
        hop_idx_d  = hop_idx_q;
        load_entry = 1'b0;
        stop_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hop_en) begin
                    state_d    = ST_SEND;
                    hop_idx_d  = 2'd0;
                    load_entry = 1'b1;
                end
            end
            ST_SEND: begin
                // Remember a disable seen mid-burst so the hop ends in IDLE.
                stop_d = stop_q | ~hop_en;
                if (send_acc && (byte_cnt_q == LAST_BYTE)) begin
                    state_d = ST_IOUP;
                end
            end
            ST_IOUP: begin
                if (stop_q || !hop_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!hop_en) begin
                    state_d = ST_IDLE;
                end else if (wait_last) begin
                    state_d    = ST_SEND;
                    hop_idx_d  = next_idx;
                    load_entry = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, table, shift buffer and counters; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            sbuf_q      <= 48'd0;
            byte_cnt_q  <= 3'd0;
            dwell_cnt_q <= 16'd0;
            hop_idx_q   <= 2'd0;
            stop_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                table_q[i] <= 48'd0;
            end
        end else begin
            state_q   <= state_d;
            hop_idx_q <= hop_idx_d;
            stop_q    <= stop_d;

            if (cfg_we) begin
                table_q[cfg_addr] <= cfg_ftw;
            end

            // Snapshot taken on SEND entry so table writes only affect later hops.
            if (load_entry) begin
                sbuf_q <= table_q[hop_idx_d];
            end else if (send_acc) begin
                sbuf_q <= {sbuf_q[39:0], 8'd0};
            end

            if (load_entry) begin
                byte_cnt_q <= 3'd0;
            end else if (send_acc) begin
                byte_cnt_q <= (byte_cnt_q == LAST_BYTE) ? 3'd0 : (byte_cnt_q + 3'd1);
            end

            // Dwell counts free-running in WAIT; host traffic does not stall it.
            if (state_q == ST_IOUP) begin
                dwell_cnt_q <= 16'd0;
            end else if (state_q == ST_WAIT) begin
                dwell_cnt_q <= dwell_cnt_q + 16'd1;
            end
        end
    end

    // Host grant: idle without a pending hop start, or any WAIT cycle but the last.
    always_comb begin
        host_grant = rstn & cmd_ready & host_valid &
                     (((state_q == ST_IDLE) & ~hop_en) |
                      ((state_q == ST_WAIT) & ~wait_last));
    end

    // Command port mux and status outputs; everything forced low while in reset.
    always_comb begin
        host_ready = host_grant;
        cmd_valid  = 1'b0;
        cmd_addr   = 6'd0;
        cmd_data   = 8'd0;
        if (host_grant) begin
            cmd_valid = 1'b1;
            cmd_addr  = host_addr;
            cmd_data  = host_data;
        end else if (rstn && (state_q == ST_SEND)) begin
            cmd_valid = 1'b1;
            cmd_addr  = 6'd4 + {3'd0, byte_cnt_q};
            cmd_data  = sbuf_q[47:40];
        end
        dds_ioup = rstn & (state_q == ST_IOUP);
        hop_done = rstn & (state_q == ST_IOUP);
        busy     = rstn & (state_q != ST_IDLE);
        hop_idx  = hop_idx_q;
    end

endmodule

// File: tb/tb_dds_hop_seq.sv
// Scoreboard bench for dds_hop_seq: expected hop bytes and hop indices are
// queued from a local copy of the table; a negedge monitor pops and compares.
module tb_dds_hop_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [47:0] cfg_ftw;
    logic        hop_en;
    logic [15:0] hop_period;
    logic [1:0]  hop_last;
    logic        host_valid;
    logic        host_ready;
    logic [5:0]  host_addr;
    logic [7:0]  host_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        dds_ioup;
    logic        busy;
    logic [1:0]  hop_idx;
    logic        hop_done;

    always #5 clk = ~clk;

    dds_hop_seq dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_ftw    (cfg_ftw),
        .hop_en     (hop_en),
        .hop_period (hop_period),
        .hop_last   (hop_last),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .dds_ioup   (dds_ioup),
        .busy       (busy),
        .hop_idx    (hop_idx),
        .hop_done   (hop_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and reference table
    logic [13:0] exp_q [$];
    logic [1:0]  idx_q [$];
    logic [47:0] tbl [4];

    // Test controls (written by stimulus only)
    logic bp_mode   = 1'b0;
    logic full_rate = 1'b0;
    int   exp_dwell = 1;

    // Monitor state (written by monitor only)
    int          cyc = 0;
    int          n_done = 0;
    int          n_hop_bytes = 0;
    int          n_host_wait = 0;
    int          nbytes = 0;
    int          burst_start = 0;
    int          last_ioup = 0;
    logic        in_burst = 1'b0;
    logic        stalled = 1'b0;
    logic [13:0] stall_val = '0;
    logic        prev_busy = 1'b0;
    logic        prev_host_acc = 1'b0;
    logic [13:0] e;
    logic [1:0]  ei;

    // cmd_ready driver: constant 1, or the 1,0,0,1 backpressure pattern
    initial begin
        int ph;
        ph = 0;
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cmd_ready = !bp_mode || (ph == 0) || (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    // Monitor: samples on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            in_burst      = 1'b0;
            stalled       = 1'b0;
            prev_busy     = 1'b0;
            prev_host_acc = 1'b0;
            exp_q.delete();
            idx_q.delete();
        end else begin
            if (stalled)
                check("stall_hold", {cmd_valid, host_ready, cmd_addr, cmd_data},
                      {1'b1, 1'b0, stall_val});
            stalled = 1'b0;
            if (cmd_valid && host_ready) begin
                check("host_cmd", {cmd_addr, cmd_data}, {host_addr, host_data});
                check("host_in_send", in_burst, 1'b0);
                if (busy) n_host_wait++;
            end
            if (cmd_valid && !host_ready) begin
                if (!in_burst) begin
                    in_burst    = 1'b1;
                    burst_start = cyc;
                    nbytes      = 0;
                    if (prev_busy) check("dwell", cyc - last_ioup - 1, exp_dwell);
                    check("host_wait_last", prev_host_acc, 1'b0);
                end
                if (cmd_ready) begin
                    nbytes++;
                    n_hop_bytes++;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("hop_cmd", {cmd_addr, cmd_data}, e);
                    end else begin
                        check("unexpected_cmd", exp_q.size(), 1);
                    end
                end else begin
                    stalled   = 1'b1;
                    stall_val = {cmd_addr, cmd_data};
                end
            end
            if (dds_ioup || hop_done) begin
                check("done_eq_ioup", hop_done, dds_ioup);
                check("burst_bytes", nbytes, 6);
                if (full_rate) check("burst_len", cyc - burst_start, 6);
                if (idx_q.size() > 0) begin
                    ei = idx_q.pop_front();
                    check("hop_idx", hop_idx, ei);
                end else begin
                    check("unexpected_hop", idx_q.size(), 1);
                end
                in_burst  = 1'b0;
                last_ioup = cyc;
                n_done++;
            end
            prev_host_acc = cmd_valid && host_ready;
            prev_busy     = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [47:0] v);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_ftw  = v;
        tick(1);
        cfg_we   = 1'b0;
        tbl[a]   = v;
    endtask

    task automatic push_hop(input logic [1:0] idx);
        logic [47:0] w;
        w = tbl[idx];
        for (int b = 0; b < 6; b++) begin
            exp_q.push_back({6'(4 + b), w[47 - 8*b -: 8]});
        end
        idx_q.push_back(idx);
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int t;
        t = 0;
        while (n_done < target && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, n_done, target);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        int t;
        t = 0;
        while (n_hop_bytes < target && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, n_hop_bytes, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hbase;
        rstn       = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = 2'd0;
        cfg_ftw    = 48'd0;
        hop_en     = 1'b0;
        hop_period = 16'd10;
        hop_last   = 2'd0;
        host_valid = 1'b1;
        host_addr  = 6'h1D;
        host_data  = 8'h10;
        for (int i = 0; i < 4; i++) tbl[i] = 48'd0;

        // Reset: all outputs low even with a host request pending
        tick(3);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_host_ready", host_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ioup", dds_ioup, 1'b0);
        check("rst_hop_done", hop_done, 1'b0);
        check("rst_cmd_addr", cmd_addr, 6'd0);
        check("rst_cmd_data", cmd_data, 8'd0);
        check("rst_hop_idx", hop_idx, 2'd0);
        rstn = 1'b1;
        tick(1);
        check("idle_host_ready", host_ready, 1'b1);
        host_valid = 1'b0;
        tick(1);

        // Basic hop, full rate, 10-cycle dwell
        cfg_write(2'd0, 48'h0123456789AB);
        hop_last = 2'd0; hop_period = 16'd10; exp_dwell = 10; full_rate = 1'b1;
        for (int i = 0; i < 3; i++) push_hop(2'd0);
        base = n_done;
        hop_en = 1'b1;
        wait_done("basic_hops", base + 3, 200);
        hop_en = 1'b0;
        tick(3);
        check("basic_idle", busy, 1'b0);
        check("basic_q_empty", exp_q.size(), 0);

        // Backpressure 1,0,0,1
        cfg_write(2'd0, 48'hFEDCBA987654);
        hop_period = 16'd3; exp_dwell = 3; full_rate = 1'b0; bp_mode = 1'b1;
        for (int i = 0; i < 2; i++) push_hop(2'd0);
        base = n_done;
        hop_en = 1'b1;
        wait_done("bp_hops", base + 2, 200);
        hop_en = 1'b0;
        tick(4);
        bp_mode = 1'b0;
        tick(2);
        check("bp_q_empty", exp_q.size(), 0);

        // Wrap at hop_last=2; entry 3 must never appear
        cfg_write(2'd0, 48'h100000000001);
        cfg_write(2'd1, 48'h2A2B2C2D2E2F);
        cfg_write(2'd2, 48'h3C3D3E3F4041);
        cfg_write(2'd3, 48'hDEADBEEFCAFE);
        hop_last = 2'd2; hop_period = 16'd2; exp_dwell = 2; full_rate = 1'b1;
        push_hop(2'd0); push_hop(2'd1); push_hop(2'd2); push_hop(2'd0); push_hop(2'd1);
        base = n_done;
        hop_en = 1'b1;
        wait_done("wrap_hops", base + 5, 300);
        hop_en = 1'b0;
        tick(3);
        check("wrap_q_empty", exp_q.size(), 0);

        // hop_period=0 behaves as a one-cycle dwell
        hop_last = 2'd0; hop_period = 16'd0; exp_dwell = 1;
        for (int i = 0; i < 2; i++) push_hop(2'd0);
        base = n_done;
        hop_en = 1'b1;
        wait_done("p0_hops", base + 2, 100);
        hop_en = 1'b0;
        tick(3);
        check("p0_q_empty", exp_q.size(), 0);

        // Disable after two bytes: hop completes, then IDLE
        hop_period = 16'd5; exp_dwell = 5;
        push_hop(2'd0);
        base = n_done;
        hbase = n_hop_bytes;
        hop_en = 1'b1;
        wait_bytes("dis_bytes", hbase + 2, 50);
        hop_en = 1'b0;
        tick(20);
        check("dis_hops", n_done, base + 1);
        check("dis_busy", busy, 1'b0);
        check("dis_q_empty", exp_q.size(), 0);

        // Arbitration: host held through hops
        hop_period = 16'd8; exp_dwell = 8;
        host_valid = 1'b1; host_addr = 6'h1D; host_data = 8'h10;
        tick(3);
        hbase = n_host_wait;
        for (int i = 0; i < 2; i++) push_hop(2'd0);
        base = n_done;
        hop_en = 1'b1;
        #1;
        check("collide_host_ready", host_ready, 1'b0);
        wait_done("arb_hops", base + 2, 200);
        hop_en = 1'b0;
        tick(2);
        host_valid = 1'b0;
        check("host_wait_cnt", n_host_wait - hbase, 8);
        check("arb_q_empty", exp_q.size(), 0);
        tick(2);

        // Reset after three bytes; restart sends a zeroed table
        cfg_write(2'd0, 48'h112233445566);
        hop_period = 16'd4; exp_dwell = 4;
        push_hop(2'd0);
        hbase = n_hop_bytes;
        hop_en = 1'b1;
        wait_bytes("rs_bytes", hbase + 3, 50);
        rstn = 1'b0;
        @(negedge clk);
        check("rs_during_valid", cmd_valid, 1'b0);
        check("rs_during_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) tbl[i] = 48'd0;
        #1;
        check("rs_after_valid", cmd_valid, 1'b0);
        check("rs_after_busy", busy, 1'b0);
        check("rs_after_idx", hop_idx, 2'd0);
        push_hop(2'd0);
        base = n_done;
        wait_done("rs_hops", base + 1, 50);
        hop_en = 1'b0;
        tick(3);
        check("rs_q_empty", exp_q.size(), 0);
        check("final_idx_q_empty", idx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dds_hop_seq.md
DDS_HOP_SEQ -- requirements
Module: dds_hop_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, and SHALL use the following ports (clock and reset first).
- clk  in  1  single block clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- cfg_we  in  1  hop-table write strobe.
- cfg_addr  in  2  hop-table entry index.
- cfg_ftw  in  48  frequency tuning word for the entry.
- hop_en  in  1  level; enables hopping.
- hop_period  in  16  dwell cycles between hops.
- hop_last  in  2  index of last table entry used; wrap point.
- host_valid  in  1  host byte-write request.
- host_ready  out  1  host request accepted this cycle.
- host_addr  in  6  host DDS register address.
- host_data  in  8  host DDS write byte.
- cmd_valid  out  1  byte-write command to DDS parallel-port controller.
- cmd_ready  in  1  controller accepts the command.
- cmd_addr  out  6  DDS register address.
- cmd_data  out  8  DDS write byte.
- dds_ioup  out  1  one-cycle I/O-update request.
- busy  out  1  high when the state is not IDLE.
- hop_idx  out  2  table index of the current or last hop.
- hop_done  out  1  one-cycle pulse after each completed hop.

Function
REQ-002 The hop table SHALL be 4 x 48-bit; cfg_we SHALL write cfg_ftw to entry cfg_addr at the clock edge, in any state.
REQ-003 The block SHALL implement a state machine with states IDLE, SEND, IOUP and WAIT.
REQ-004 IDLE with hop_en=1 SHALL go to SEND with hop_idx=0.
REQ-005 On entry to SEND, the selected entry SHALL be latched into a 48-bit shift buffer; cfg writes to that entry during the hop SHALL affect only its next use.
REQ-006 SEND SHALL issue 6 commands, MSB first: addresses 0x04..0x09 with data FTW[47:40]..FTW[7:0].
REQ-007 In SEND, cmd_valid SHALL be 1, and cmd_addr/cmd_data SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-008 The byte counter SHALL advance only on cmd_valid&cmd_ready; accepting byte 5 (address 0x09) SHALL go to IOUP.
REQ-009 IOUP SHALL last one cycle with dds_ioup=1 and hop_done=1, then go to WAIT with the dwell counter cleared.
REQ-010 WAIT SHALL last max(hop_period,1) cycles; hop_period=0 SHALL be treated as 1.
REQ-011 At the end of WAIT, the block SHALL go to SEND with hop_idx = (hop_idx==hop_last) ? 0 : hop_idx+1.
REQ-012 hop_last changes SHALL be sampled at the index update; if hop_idx>hop_last then, the next index SHALL be 0.
REQ-013 hop_en=0 in WAIT SHALL return to IDLE next cycle.
REQ-014 hop_en=0 in SEND or IOUP SHALL complete the hop (all 6 bytes plus IOUP) and then go to IDLE, never WAIT; no partial FTW SHALL ever be left.
REQ-015 Host arbitration: host_ready SHALL equal cmd_ready & host_valid & (state IDLE, or WAIT not in its final cycle).
- When host_ready=1, cmd_valid/addr/data SHALL be driven from the host inputs combinationally.
REQ-016 A hop start in the same cycle as a host request SHALL win; host_ready=0 and the host holds its request.
REQ-017 Host transfers SHALL NOT pause or extend the dwell counter; busy SHALL remain 1 in WAIT.
REQ-018 In SEND, host_ready SHALL be 0 (the burst is atomic).
REQ-019 hop_done and dds_ioup SHALL never assert outside IOUP.

Reset
REQ-020 rstn=0 at a clock edge SHALL force IDLE and clear the table, shift buffer, byte counter, dwell counter and hop_idx to 0.
REQ-021 During and after reset, all outputs SHALL be 0 (cmd_valid, cmd_addr, cmd_data, dds_ioup, busy, hop_done, host_ready).
REQ-022 Reset mid-SEND SHALL abort the burst immediately; cmd_valid SHALL be 0 the next cycle.

Verification
REQ-023 Basic hop: entry0=0x0123456789AB, hop_last=0, hop_period=10, cmd_ready=1, hop_en=1 -> commands (04,01),(05,23),(06,45),(07,67),(08,89),(09,AB) on consecutive cycles, dds_ioup one cycle later, next SEND exactly 10 cycles after IOUP.
REQ-024 Backpressure: cmd_ready toggling 1,0,0,1,... -> no byte lost or duplicated, addr/data held while stalled, 6 accepts total per hop.
REQ-025 Wrap: entries 0..3 distinct, hop_last=2 -> hop_idx sequence 0,1,2,0,1; entry 3 never sent.
REQ-026 Disable mid-burst: hop_en dropped after the 2nd byte accepted -> the remaining 4 bytes and IOUP complete, then IDLE and busy=0; no further commands.
REQ-027 Arbitration: host_valid (addr 0x1D, data 0x10) held through a hop -> accepted only in IDLE/WAIT, never in SEND; dwell length unchanged; hop start wins a same-cycle collision.
REQ-028 Reset in SEND after 3 bytes -> all outputs 0 the next cycle; after release with hop_en=1, the hop restarts at entry 0 with table=0 (data bytes 0x00).
